chan_fifo_hub: RTL and testbench

//  Parametrised bank of NUM_CHANS FIFO pairs behind the comm_fpga channel interface.
//  Per pair k:
//   - Write FIFO k: the host fills it; local logic drains it.
//   - Read FIFO k: local logic fills it; the host drains it.
//   - A status channel returns the depth and accepts a flush command.

---
 rtl/chan_fifo_hub.sv | 202 ++++++++++++++++++++
 tb/tb_chan_fifo_hub.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/chan_fifo_hub.sv
// chan_fifo_hub: a bank of NUM_CHANS FIFO pairs behind the comm_fpga channel interface.
//   Pair k, with d = chanAddr_in - ADDR_BASE:
//     d = 2k   : data channel. Host writes push write FIFO k; host reads pop read FIFO k.
//     d = 2k+1 : status channel. Reads return the write FIFO k count. Writes with bit 0 set
//                flush both FIFOs of pair k.
//   With FIFO_HWM_EN defined, reads at d = 2*NUM_CHANS+k return the write FIFO k
//   high-water mark and reload it with the current count.
//   Unmapped addresses accept and discard writes. Reads there return 8'h00.
// Ports:
//   clk_in, reset_n_in               clock, async active-low reset
//   chanAddr_in                      selected channel
//   h2fData_in/Valid_in/Ready_out    host->FPGA byte stream
//   f2hData_out/Valid_out/Ready_in   FPGA->host byte stream
//   wrData_out/Valid_out/Ready_in    write FIFO heads toward local consumers (8 bits per pair)
//   rdData_in/Valid_in/Ready_out     local producers into the read FIFOs (8 bits per pair)
// Optional feature macro: FIFO_HWM_EN
module chan_fifo_hub #(
  parameter int unsigned NUM_CHANS  = 2,
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned ADDR_BASE  = 0
) (
  input  logic                   clk_in,
  input  logic                   reset_n_in,
  input  logic [6:0]             chanAddr_in,
  input  logic [7:0]             h2fData_in,
  input  logic                   h2fValid_in,
  output logic                   h2fReady_out,
  output logic [7:0]             f2hData_out,
  output logic                   f2hValid_out,
  input  logic                   f2hReady_in,
  output logic [8*NUM_CHANS-1:0] wrData_out,
  output logic [NUM_CHANS-1:0]   wrValid_out,
  input  logic [NUM_CHANS-1:0]   wrReady_in,
  input  logic [8*NUM_CHANS-1:0] rdData_in,
  input  logic [NUM_CHANS-1:0]   rdValid_in,
  output logic [NUM_CHANS-1:0]   rdReady_out
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   cnt_t;

  localparam cnt_t CntFull = cnt_t'(Depth);

  // Storage is not reset; heads are only meaningful while the count is non-zero.
  logic [7:0] wmem [NUM_CHANS][Depth];
  logic [7:0] rmem [NUM_CHANS][Depth];

  ptr_t wwr_ptr_q [NUM_CHANS];
  ptr_t wwr_ptr_d [NUM_CHANS];
  ptr_t wrd_ptr_q [NUM_CHANS];
  ptr_t wrd_ptr_d [NUM_CHANS];
  ptr_t rwr_ptr_q [NUM_CHANS];
  ptr_t rwr_ptr_d [NUM_CHANS];
  ptr_t rrd_ptr_q [NUM_CHANS];
  ptr_t rrd_ptr_d [NUM_CHANS];
  cnt_t wcnt_q    [NUM_CHANS];
  cnt_t wcnt_d    [NUM_CHANS];
  cnt_t rcnt_q    [NUM_CHANS];
  cnt_t rcnt_d    [NUM_CHANS];
`ifdef FIFO_HWM_EN
  cnt_t hwm_q     [NUM_CHANS];
  cnt_t hwm_d     [NUM_CHANS];
  logic [NUM_CHANS-1:0] sel_hwm;
`endif

  logic [NUM_CHANS-1:0] sel_data, sel_stat;
  logic [NUM_CHANS-1:0] w_push, w_pop, r_push, r_pop, flush;
  logic [7:0]           d_off;

  // Addresses below ADDR_BASE wrap to >= 128, which is always unmapped.
  assign d_off = {1'b0, chanAddr_in} - 8'(ADDR_BASE);

  always_comb begin
    sel_data = '0;
    sel_stat = '0;
    w_push   = '0;
    w_pop    = '0;
    r_push   = '0;
    r_pop    = '0;
    flush    = '0;
`ifdef FIFO_HWM_EN
    sel_hwm  = '0;
`endif
    for (int k = 0; k < NUM_CHANS; k++) begin
      sel_data[k] = (d_off == 8'(2 * k));
      sel_stat[k] = (d_off == 8'(2 * k + 1));
      flush[k]    = h2fValid_in & sel_stat[k] & h2fData_in[0];
      w_push[k]   = h2fValid_in & sel_data[k] & (wcnt_q[k] != CntFull);
      r_pop[k]    = f2hReady_in & sel_data[k] & (rcnt_q[k] != '0);
      // A flush overrides same-edge local traffic on its pair.
      w_pop[k]    = wrReady_in[k] & (wcnt_q[k] != '0) & ~flush[k];
      r_push[k]   = rdValid_in[k] & (rcnt_q[k] != CntFull) & ~flush[k];
`ifdef FIFO_HWM_EN
      sel_hwm[k]  = (d_off == 8'(2 * NUM_CHANS + k));
`endif
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_CHANS; k++) begin
      wwr_ptr_d[k] = wwr_ptr_q[k];
      wrd_ptr_d[k] = wrd_ptr_q[k];
      rwr_ptr_d[k] = rwr_ptr_q[k];
      rrd_ptr_d[k] = rrd_ptr_q[k];
      wcnt_d[k]    = wcnt_q[k];
      rcnt_d[k]    = rcnt_q[k];
      if (flush[k]) begin
        wwr_ptr_d[k] = '0;
        wrd_ptr_d[k] = '0;
        rwr_ptr_d[k] = '0;
        rrd_ptr_d[k] = '0;
        wcnt_d[k]    = '0;
        rcnt_d[k]    = '0;
      end else begin
        if (w_push[k]) wwr_ptr_d[k] = wwr_ptr_q[k] + ptr_t'(1);
        if (w_pop[k])  wrd_ptr_d[k] = wrd_ptr_q[k] + ptr_t'(1);
        if (r_push[k]) rwr_ptr_d[k] = rwr_ptr_q[k] + ptr_t'(1);
        if (r_pop[k])  rrd_ptr_d[k] = rrd_ptr_q[k] + ptr_t'(1);
        if (w_push[k] && !w_pop[k]) wcnt_d[k] = wcnt_q[k] + cnt_t'(1);
        if (w_pop[k] && !w_push[k]) wcnt_d[k] = wcnt_q[k] - cnt_t'(1);
        if (r_push[k] && !r_pop[k]) rcnt_d[k] = rcnt_q[k] + cnt_t'(1);
        if (r_pop[k] && !r_push[k]) rcnt_d[k] = rcnt_q[k] - cnt_t'(1);
      end
    end
  end

`ifdef FIFO_HWM_EN
  always_comb begin
    for (int k = 0; k < NUM_CHANS; k++) begin
      hwm_d[k] = hwm_q[k];
      if (flush[k]) begin
        hwm_d[k] = '0;
      end else if (f2hReady_in && sel_hwm[k]) begin
        hwm_d[k] = wcnt_d[k];
      end else if (wcnt_d[k] > hwm_q[k]) begin
        hwm_d[k] = wcnt_d[k];
      end
    end
  end
`endif

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      for (int k = 0; k < NUM_CHANS; k++) begin
        wwr_ptr_q[k] <= '0;
        wrd_ptr_q[k] <= '0;
        rwr_ptr_q[k] <= '0;
        rrd_ptr_q[k] <= '0;
        wcnt_q[k]    <= '0;
        rcnt_q[k]    <= '0;
`ifdef FIFO_HWM_EN
        hwm_q[k]     <= '0;
`endif
      end
    end else begin
      for (int k = 0; k < NUM_CHANS; k++) begin
        wwr_ptr_q[k] <= wwr_ptr_d[k];
        wrd_ptr_q[k] <= wrd_ptr_d[k];
        rwr_ptr_q[k] <= rwr_ptr_d[k];
        rrd_ptr_q[k] <= rrd_ptr_d[k];
        wcnt_q[k]    <= wcnt_d[k];
        rcnt_q[k]    <= rcnt_d[k];
`ifdef FIFO_HWM_EN
        hwm_q[k]     <= hwm_d[k];
`endif
      end
    end
  end

  always_ff @(posedge clk_in) begin
    for (int k = 0; k < NUM_CHANS; k++) begin
      if (w_push[k]) wmem[k][wwr_ptr_q[k]] <= h2fData_in;
      if (r_push[k]) rmem[k][rwr_ptr_q[k]] <= rdData_in[8*k +: 8];
    end
  end

  always_comb begin
    h2fReady_out = 1'b1;
    f2hValid_out = 1'b1;
    f2hData_out  = 8'h00;
    wrData_out   = '0;
    wrValid_out  = '0;
    rdReady_out  = '0;
    for (int k = 0; k < NUM_CHANS; k++) begin
      wrData_out[8*k +: 8] = wmem[k][wrd_ptr_q[k]];
      wrValid_out[k]       = (wcnt_q[k] != '0);
      rdReady_out[k]       = (rcnt_q[k] != CntFull);
      if (sel_data[k]) begin
        h2fReady_out = (wcnt_q[k] != CntFull);
        f2hValid_out = (rcnt_q[k] != '0);
        f2hData_out  = rmem[k][rrd_ptr_q[k]];
      end
      if (sel_stat[k]) f2hData_out = 8'(wcnt_q[k]);
`ifdef FIFO_HWM_EN
      if (sel_hwm[k]) f2hData_out = 8'(hwm_q[k]);
`endif
    end
  end

endmodule

// File: tb/tb_chan_fifo_hub.sv
module tb_chan_fifo_hub;

  logic        clk_in = 1'b0;
  logic        reset_n_in;
  logic [6:0]  chanAddr_in;
  logic [7:0]  h2fData_in;
  logic        h2fValid_in;
  logic        h2fReady_out;
  logic [7:0]  f2hData_out;
  logic        f2hValid_out;
  logic        f2hReady_in;
  logic [15:0] wrData_out;
  logic [1:0]  wrValid_out;
  logic [1:0]  wrReady_in;
  logic [15:0] rdData_in;
  logic [1:0]  rdValid_in;
  logic [1:0]  rdReady_out;

  int n_checks = 0;
  int n_errors = 0;

  chan_fifo_hub #(
    .NUM_CHANS (2),
    .DEPTH_LOG2(4),
    .ADDR_BASE (0)
  ) dut (
    .clk_in      (clk_in),
    .reset_n_in  (reset_n_in),
    .chanAddr_in (chanAddr_in),
    .h2fData_in  (h2fData_in),
    .h2fValid_in (h2fValid_in),
    .h2fReady_out(h2fReady_out),
    .f2hData_out (f2hData_out),
    .f2hValid_out(f2hValid_out),
    .f2hReady_in (f2hReady_in),
    .wrData_out  (wrData_out),
    .wrValid_out (wrValid_out),
    .wrReady_in  (wrReady_in),
    .rdData_in   (rdData_in),
    .rdValid_in  (rdValid_in),
    .rdReady_out (rdReady_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #1ms;
    $display("FAIL watchdog: time limit reached, required finish before 1ms");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; the rising edge in between applies them.
  task automatic step();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic host_wr(input logic [6:0] a, input logic [7:0] dat);
    chanAddr_in = a;
    h2fData_in  = dat;
    h2fValid_in = 1'b1;
    step();
    h2fValid_in = 1'b0;
  endtask

  task automatic host_rd(input logic [6:0] a, output logic [7:0] dat, output logic v);
    chanAddr_in = a;
    f2hReady_in = 1'b1;
    #1;
    dat = f2hData_out;
    v   = f2hValid_out;
    step();
    f2hReady_in = 1'b0;
  endtask

  task automatic rd_push(input int k, input logic [7:0] dat);
    rdValid_in[k]       = 1'b1;
    rdData_in[8*k +: 8] = dat;
    step();
    rdValid_in[k] = 1'b0;
  endtask

  logic [7:0] rd;
  logic       rv;

  initial begin
    reset_n_in  = 1'b0;
    chanAddr_in = '0;
    h2fData_in  = '0;
    h2fValid_in = 1'b0;
    f2hReady_in = 1'b0;
    wrReady_in  = '0;
    rdData_in   = '0;
    rdValid_in  = '0;
    repeat (2) @(negedge clk_in);
    reset_n_in = 1'b1;
    @(negedge clk_in);

    // Reset state
    check_eq("rst_wr_valid", 32'(wrValid_out), 32'h0);
    check_eq("rst_rd_ready", 32'(rdReady_out), 32'h3);
    host_rd(7'd1, rd, rv);
    check_eq("rst_stat1", 32'(rd), 32'h00);

    // Fill write FIFO 0 to full; the 17th byte must be held off
    for (int i = 0; i < 16; i++) begin
      chanAddr_in = 7'd0;
      #1;
      check_eq("fill_h2f_ready", 32'(h2fReady_out), 32'h1);
      host_wr(7'd0, 8'(i));
    end
    chanAddr_in = 7'd0;
    h2fData_in  = 8'h10;
    h2fValid_in = 1'b1;
    #1;
    check_eq("full_h2f_ready", 32'(h2fReady_out), 32'h0);
    step();
    h2fValid_in = 1'b0;
    host_rd(7'd1, rd, rv);
    check_eq("full_stat1", 32'(rd), 32'h10);
    check_eq("full_head", 32'(wrData_out[7:0]), 32'h00);
    for (int i = 0; i < 16; i++) begin
      check_eq("drain0_valid", 32'(wrValid_out[0]), 32'h1);
      check_eq("drain0_data", 32'(wrData_out[7:0]), 32'(i));
      wrReady_in[0] = 1'b1;
      step();
      wrReady_in[0] = 1'b0;
    end
    check_eq("drain0_empty", 32'(wrValid_out[0]), 32'h0);

    // Concurrent stream on pair 1 at count 5
    for (int i = 0; i < 5; i++) host_wr(7'd2, 8'(8'h20 + i));
    host_rd(7'd3, rd, rv);
    check_eq("stream_stat_pre", 32'(rd), 32'h5);
    for (int i = 0; i < 8; i++) begin
      chanAddr_in   = 7'd2;
      h2fData_in    = 8'(8'h25 + i);
      h2fValid_in   = 1'b1;
      wrReady_in[1] = 1'b1;
      #1;
      check_eq("stream_ready", 32'(h2fReady_out), 32'h1);
      check_eq("stream_head", 32'(wrData_out[15:8]), 32'(8'h20 + i));
      step();
      h2fValid_in   = 1'b0;
      wrReady_in[1] = 1'b0;
    end
    host_rd(7'd3, rd, rv);
    check_eq("stream_stat_post", 32'(rd), 32'h5);
    for (int i = 0; i < 5; i++) begin
      check_eq("stream_tail", 32'(wrData_out[15:8]), 32'(8'h28 + i));
      wrReady_in[1] = 1'b1;
      step();
      wrReady_in[1] = 1'b0;
    end
    check_eq("stream_empty", 32'(wrValid_out[1]), 32'h0);

    // Read FIFO 0: fill, refuse overflow, drain in order, then empty
    for (int i = 0; i < 16; i++) begin
      check_eq("rfill_ready", 32'(rdReady_out[0]), 32'h1);
      rd_push(0, 8'(8'hA5 + i));
    end
    check_eq("rfull_ready", 32'(rdReady_out[0]), 32'h0);
    rd_push(0, 8'hEE);
    check_eq("rfull_ready_hold", 32'(rdReady_out[0]), 32'h0);
    for (int i = 0; i < 16; i++) begin
      host_rd(7'd0, rd, rv);
      check_eq("rdrain_valid", 32'(rv), 32'h1);
      check_eq("rdrain_data", 32'(rd), 32'(8'hA5 + i));
    end
    host_rd(7'd0, rd, rv);
    check_eq("rempty_valid", 32'(rv), 32'h0);

    // Unmapped address
    chanAddr_in = 7'h10;
    #1;
    check_eq("unmap_h2f_ready", 32'(h2fReady_out), 32'h1);
    check_eq("unmap_f2h_valid", 32'(f2hValid_out), 32'h1);
    check_eq("unmap_data", 32'(f2hData_out), 32'h00);
    @(negedge clk_in);

    // Flush pair 1 with a same-edge local push
    for (int i = 0; i < 3; i++) host_wr(7'd2, 8'(8'h50 + i));
    for (int i = 0; i < 3; i++) rd_push(1, 8'(8'h60 + i));
    host_wr(7'd3, 8'h02);
    host_rd(7'd3, rd, rv);
    check_eq("noflush_stat", 32'(rd), 32'h3);
    chanAddr_in   = 7'd3;
    h2fData_in    = 8'h01;
    h2fValid_in   = 1'b1;
    rdValid_in[1] = 1'b1;
    rdData_in[15:8] = 8'h77;
    step();
    h2fValid_in   = 1'b0;
    rdValid_in[1] = 1'b0;
    check_eq("flush_wr_valid", 32'(wrValid_out[1]), 32'h0);
    host_rd(7'd2, rd, rv);
    check_eq("flush_rd_empty", 32'(rv), 32'h0);
    host_rd(7'd3, rd, rv);
    check_eq("flush_stat", 32'(rd), 32'h0);
    rd_push(1, 8'h88);
    host_rd(7'd2, rd, rv);
    check_eq("post_flush_valid", 32'(rv), 32'h1);
    check_eq("post_flush_data", 32'(rd), 32'h88);

`ifdef FIFO_HWM_EN
    host_rd(7'd4, rd, rv);
    check_eq("hwm_initial", 32'(rd), 32'h10);
    for (int i = 0; i < 9; i++) host_wr(7'd0, 8'(i));
    for (int i = 0; i < 7; i++) begin
      wrReady_in[0] = 1'b1;
      step();
      wrReady_in[0] = 1'b0;
    end
    host_rd(7'd4, rd, rv);
    check_eq("hwm_peak", 32'(rd), 32'h09);
    host_rd(7'd4, rd, rv);
    check_eq("hwm_reload", 32'(rd), 32'h02);
`else
    host_rd(7'd4, rd, rv);
    check_eq("hwm_unmapped_valid", 32'(rv), 32'h1);
    check_eq("hwm_unmapped_data", 32'(rd), 32'h00);
`endif

    // Reset mid-transfer drops buffered data
    host_wr(7'd0, 8'hC1);
    host_wr(7'd0, 8'hC2);
    rd_push(0, 8'hC3);
    #2;
    reset_n_in = 1'b0;
    #1;
    check_eq("midrst_wr_valid", 32'(wrValid_out), 32'h0);
    check_eq("midrst_rd_ready", 32'(rdReady_out), 32'h3);
    @(negedge clk_in);
    reset_n_in = 1'b1;
    @(negedge clk_in);
    host_rd(7'd0, rd, rv);
    check_eq("midrst_rd_empty", 32'(rv), 32'h0);
    host_rd(7'd1, rd, rv);
    check_eq("midrst_stat1", 32'(rd), 32'h00);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
